// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and the data memory (slave).
// Address, direction and write data are held stable for as long as a request goes unacknowledged.
interface mem_wb_stage_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ack;
    logic        err;
    logic [63:0] rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// Y86-64 memory stage and M->W pipeline register. Issues 8-byte loads/stores over a req/ack bus,
// stalls upstream while waiting, and reports range, bus-error and timeout faults as SADR.
module mem_wb_stage #(
    parameter int MEM_BYTES = 4096,
    parameter int TIMEOUT   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            M_icode_i,
    input  logic [2:0]            M_stat_i,
    input  logic [63:0]           M_valE_i,
    input  logic [63:0]           M_valA_i,
    input  logic [3:0]            M_dstE_i,
    input  logic [3:0]            M_dstM_i,
    mem_wb_stage_if.master        dmem,
    output logic [63:0]           m_valM_o,
    output logic [2:0]            m_stat_o,
    output logic                  m_busy_o,
    output logic [3:0]            W_icode_o,
    output logic [2:0]            W_stat_o,
    output logic [63:0]           W_valE_o,
    output logic [63:0]           W_valM_o,
    output logic [3:0]            W_dstE_o,
    output logic [3:0]            W_dstM_o
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam int         CW       = $clog2(TIMEOUT) + 1;
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_wait_cnt, w_wait_cnt_nxt;
    logic            w_is_read, w_is_write, w_enabled, w_range_fault, w_timeout_hit;
    logic            w_req, w_done;
    logic [63:0]     w_addr;

    assign w_is_read  = (M_icode_i == I_MRMOVQ) || (M_icode_i == I_POPQ) || (M_icode_i == I_RET);
    assign w_is_write = (M_icode_i == I_RMMOVQ) || (M_icode_i == I_PUSHQ) || (M_icode_i == I_CALL);
    assign w_addr     = ((M_icode_i == I_POPQ) || (M_icode_i == I_RET)) ? M_valA_i : M_valE_i;

    // A fault already sitting in W blocks further memory side effects.
    assign w_enabled     = (w_is_read || w_is_write) && (M_stat_i == S_AOK) && (W_stat_o == S_AOK);
    assign w_range_fault = w_enabled && (w_addr > ADDR_MAX);
    assign w_timeout_hit = (r_state == ST_WAIT) && (r_wait_cnt == CW'(TIMEOUT - 1)) && !dmem.ack;
    assign w_req         = w_enabled && !w_range_fault && !w_timeout_hit && !rst_i;
    assign w_done        = w_req && dmem.ack;

    assign dmem.req   = w_req;
    assign dmem.we    = w_is_write;
    assign dmem.addr  = w_addr;
    assign dmem.wdata = M_valA_i;
    assign m_busy_o   = w_req && !dmem.ack;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        m_stat_o = M_stat_i;
        m_valM_o = '0;
        if (w_range_fault || w_timeout_hit || (w_done && dmem.err)) begin
            m_stat_o = S_ADR;
        end else if (w_done && w_is_read) begin
            m_valM_o = dmem.rdata;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = '0;
        case (r_state)
            ST_IDLE: if (w_req && !dmem.ack) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (dmem.ack || w_timeout_hit) w_state_nxt = ST_IDLE;
                else                           w_wait_cnt_nxt = r_wait_cnt + CW'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            W_icode_o <= I_NOP;
            W_stat_o  <= S_AOK;
            W_valE_o  <= '0;
            W_valM_o  <= '0;
            W_dstE_o  <= R_NONE;
            W_dstM_o  <= R_NONE;
        end else if (W_stat_o == S_AOK) begin
            if (m_busy_o) begin
                W_icode_o <= I_NOP;
                W_stat_o  <= S_AOK;
                W_valE_o  <= '0;
                W_valM_o  <= '0;
                W_dstE_o  <= R_NONE;
                W_dstM_o  <= R_NONE;
            end else begin
                W_icode_o <= M_icode_i;
                W_stat_o  <= m_stat_o;
                W_valE_o  <= M_valE_i;
                W_valM_o  <= m_valM_o;
                W_dstE_o  <= M_dstE_i;
                W_dstM_o  <= M_dstM_i;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: each task drives one scenario and compares against hand-computed values.
`timescale 1ns/1ps
module tb_mem_wb_stage;
    localparam logic [3:0] I_NOP = 4'h1, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6;
    localparam logic [3:0] I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB, R_NONE = 4'hF;
    localparam logic [2:0] S_AOK = 3'd1, S_ADR = 3'd3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  M_icode_i, M_dstE_i, M_dstM_i;
    logic [2:0]  M_stat_i;
    logic [63:0] M_valE_i, M_valA_i;
    logic [63:0] m_valM_o, W_valE_o, W_valM_o;
    logic [2:0]  m_stat_o, W_stat_o;
    logic        m_busy_o;
    logic [3:0]  W_icode_o, W_dstE_o, W_dstM_o;
    int          total = 0;
    int          bad = 0;

    mem_wb_stage_if dmem ();

    mem_wb_stage #(.MEM_BYTES(4096), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .M_icode_i(M_icode_i), .M_stat_i(M_stat_i), .M_valE_i(M_valE_i), .M_valA_i(M_valA_i),
        .M_dstE_i(M_dstE_i), .M_dstM_i(M_dstM_i), .dmem(dmem.master),
        .m_valM_o(m_valM_o), .m_stat_o(m_stat_o), .m_busy_o(m_busy_o),
        .W_icode_o(W_icode_o), .W_stat_o(W_stat_o), .W_valE_o(W_valE_o), .W_valM_o(W_valM_o),
        .W_dstE_o(W_dstE_o), .W_dstM_o(W_dstM_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_m(input logic [3:0] icode, input logic [63:0] vale, input logic [63:0] vala,
                           input logic [3:0] dste, input logic [3:0] dstm);
        M_icode_i = icode; M_stat_i = S_AOK; M_valE_i = vale; M_valA_i = vala;
        M_dstE_i = dste; M_dstM_i = dstm;
    endtask

    task automatic drive_mem(input logic ack, input logic err, input logic [63:0] rdata);
        dmem.ack = ack; dmem.err = err; dmem.rdata = rdata;
    endtask

    task automatic next_edge();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive_m(I_NOP, 64'h0, 64'h0, R_NONE, R_NONE);
        drive_mem(1'b0, 1'b0, 64'h0);
        next_edge();
        total++; if (W_icode_o !== I_NOP) begin bad++; $display("FAIL reset_W_icode got=%0h want=%0h", W_icode_o, I_NOP); end
        total++; if (W_stat_o !== S_AOK) begin bad++; $display("FAIL reset_W_stat got=%0d want=%0d", W_stat_o, S_AOK); end
        total++; if (W_dstE_o !== R_NONE || W_dstM_o !== R_NONE) begin bad++; $display("FAIL reset_W_dst got=%0h/%0h want=f/f", W_dstE_o, W_dstM_o); end
        total++; if (dmem.req !== 1'b0 || m_busy_o !== 1'b0) begin bad++; $display("FAIL reset_req_busy got=%0b/%0b want=0/0", dmem.req, m_busy_o); end
        rst_i = 1'b0;
        next_edge();
    endtask

    task automatic test_load_zero_wait();
        drive_m(I_MRMOVQ, 64'h100, 64'h0, R_NONE, 4'h3);
        drive_mem(1'b1, 1'b0, 64'hDEAD);
        @(negedge clk_i);
        total++; if (dmem.req !== 1'b1 || dmem.we !== 1'b0 || dmem.addr !== 64'h100) begin bad++; $display("FAIL load_req got=%0b/%0b/%0h want=1/0/100", dmem.req, dmem.we, dmem.addr); end
        total++; if (m_busy_o !== 1'b0 || m_valM_o !== 64'hDEAD) begin bad++; $display("FAIL load_comb got busy=%0b valM=%0h want 0/dead", m_busy_o, m_valM_o); end
        next_edge();
        total++; if (W_icode_o !== I_MRMOVQ || W_valM_o !== 64'hDEAD || W_stat_o !== S_AOK || W_dstM_o !== 4'h3) begin
            bad++; $display("FAIL load_W got icode=%0h valM=%0h stat=%0d dstM=%0h want 5/dead/1/3", W_icode_o, W_valM_o, W_stat_o, W_dstM_o); end
        drive_m(I_NOP, 64'h0, 64'h0, R_NONE, R_NONE);
        drive_mem(1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_boundary_addr();
        drive_m(I_MRMOVQ, 64'hFF8, 64'h0, R_NONE, 4'h2);
        drive_mem(1'b1, 1'b0, 64'h55);
        @(negedge clk_i);
        total++; if (dmem.req !== 1'b1 || m_stat_o !== S_AOK || m_valM_o !== 64'h55) begin
            bad++; $display("FAIL boundary_ff8 got req=%0b stat=%0d valM=%0h want 1/1/55", dmem.req, m_stat_o, m_valM_o); end
        next_edge();
        drive_m(I_NOP, 64'h0, 64'h0, R_NONE, R_NONE);
        drive_mem(1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_store_wait();
        drive_m(I_PUSHQ, 64'h1F8, 64'h7, 4'h4, R_NONE);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) drive_mem(1'b1, 1'b0, 64'h0);
            @(negedge clk_i);
            total++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || dmem.addr !== 64'h1F8 || dmem.wdata !== 64'h7) begin
                bad++; $display("FAIL store_bus c=%0d got req=%0b we=%0b addr=%0h wdata=%0h want 1/1/1f8/7", c, dmem.req, dmem.we, dmem.addr, dmem.wdata); end
            total++; if (m_busy_o !== (c < 3)) begin bad++; $display("FAIL store_busy c=%0d got=%0b want=%0b", c, m_busy_o, (c < 3)); end
            next_edge();
            if (c < 3) begin
                total++; if (W_icode_o !== I_NOP || W_dstE_o !== R_NONE) begin bad++; $display("FAIL store_bubble c=%0d got icode=%0h dstE=%0h want 1/f", c, W_icode_o, W_dstE_o); end
            end else begin
                total++; if (W_icode_o !== I_PUSHQ || W_stat_o !== S_AOK || W_valE_o !== 64'h1F8 || W_dstE_o !== 4'h4) begin
                    bad++; $display("FAIL store_W got icode=%0h stat=%0d valE=%0h dstE=%0h want a/1/1f8/4", W_icode_o, W_stat_o, W_valE_o, W_dstE_o); end
            end
        end
        drive_m(I_NOP, 64'h0, 64'h0, R_NONE, R_NONE);
        drive_mem(1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_back_to_back();
        drive_m(I_OPQ, 64'h42, 64'h0, 4'h1, R_NONE);
        @(negedge clk_i);
        total++; if (dmem.req !== 1'b0 || m_busy_o !== 1'b0) begin bad++; $display("FAIL opq_noreq got req=%0b busy=%0b want 0/0", dmem.req, m_busy_o); end
        next_edge();
        total++; if (W_icode_o !== I_OPQ || W_valE_o !== 64'h42 || W_dstE_o !== 4'h1) begin bad++; $display("FAIL opq_W got icode=%0h valE=%0h dstE=%0h want 6/42/1", W_icode_o, W_valE_o, W_dstE_o); end
        drive_m(I_POPQ, 64'h210, 64'h208, 4'h4, 4'h0);
        drive_mem(1'b1, 1'b0, 64'h9);
        @(negedge clk_i);
        total++; if (dmem.addr !== 64'h208 || dmem.req !== 1'b1) begin bad++; $display("FAIL pop_addr got addr=%0h req=%0b want 208/1", dmem.addr, dmem.req); end
        next_edge();
        total++; if (W_icode_o !== I_POPQ || W_valM_o !== 64'h9 || W_valE_o !== 64'h210) begin bad++; $display("FAIL pop_W got icode=%0h valM=%0h valE=%0h want b/9/210", W_icode_o, W_valM_o, W_valE_o); end
        drive_m(I_NOP, 64'h0, 64'h0, R_NONE, R_NONE);
        drive_mem(1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_range_fault();
        drive_m(I_POPQ, 64'h0, 64'hFF9, 4'h4, 4'h0);
        @(negedge clk_i);
        total++; if (dmem.req !== 1'b0 || m_stat_o !== S_ADR || m_busy_o !== 1'b0) begin
            bad++; $display("FAIL range_comb got req=%0b stat=%0d busy=%0b want 0/3/0", dmem.req, m_stat_o, m_busy_o); end
        next_edge();
        total++; if (W_stat_o !== S_ADR || W_icode_o !== I_POPQ || W_dstM_o !== 4'h0) begin bad++; $display("FAIL range_W got stat=%0d icode=%0h dstM=%0h want 3/b/0", W_stat_o, W_icode_o, W_dstM_o); end
        drive_m(I_OPQ, 64'h77, 64'h0, 4'h2, R_NONE);
        next_edge();
        total++; if (W_icode_o !== I_POPQ || W_stat_o !== S_ADR) begin bad++; $display("FAIL range_hold got icode=%0h stat=%0d want b/3", W_icode_o, W_stat_o); end
        test_reset();
    endtask

    task automatic test_timeout();
        drive_m(I_RET, 64'h0, 64'h200, R_NONE, R_NONE);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            total++; if (dmem.req !== 1'b1 || m_busy_o !== 1'b1) begin bad++; $display("FAIL timeout_wait c=%0d got req=%0b busy=%0b want 1/1", c, dmem.req, m_busy_o); end
            next_edge();
        end
        @(negedge clk_i);
        total++; if (dmem.req !== 1'b0 || m_busy_o !== 1'b0 || m_stat_o !== S_ADR) begin
            bad++; $display("FAIL timeout_hit got req=%0b busy=%0b stat=%0d want 0/0/3", dmem.req, m_busy_o, m_stat_o); end
        next_edge();
        total++; if (W_stat_o !== S_ADR || W_icode_o !== I_RET) begin bad++; $display("FAIL timeout_W got stat=%0d icode=%0h want 3/9", W_stat_o, W_icode_o); end
        test_reset();
    endtask

    task automatic test_bus_error();
        drive_m(I_RMMOVQ, 64'h40, 64'h5, R_NONE, R_NONE);
        drive_mem(1'b1, 1'b1, 64'hABCD);
        @(negedge clk_i);
        total++; if (dmem.req !== 1'b1 || m_stat_o !== S_ADR || m_valM_o !== 64'h0) begin
            bad++; $display("FAIL buserr_comb got req=%0b stat=%0d valM=%0h want 1/3/0", dmem.req, m_stat_o, m_valM_o); end
        next_edge();
        total++; if (W_stat_o !== S_ADR) begin bad++; $display("FAIL buserr_W got stat=%0d want 3", W_stat_o); end
        drive_m(I_MRMOVQ, 64'h80, 64'h0, R_NONE, 4'h1);
        drive_mem(1'b0, 1'b0, 64'h0);
        @(negedge clk_i);
        total++; if (dmem.req !== 1'b0 || m_stat_o !== S_AOK) begin bad++; $display("FAIL buserr_block got req=%0b stat=%0d want 0/1", dmem.req, m_stat_o); end
        next_edge();
        test_reset();
    endtask

    task automatic test_reset_mid_wait();
        drive_m(I_MRMOVQ, 64'h300, 64'h0, R_NONE, 4'h6);
        next_edge();
        next_edge();
        total++; if (m_busy_o !== 1'b1) begin bad++; $display("FAIL midwait_busy got=%0b want=1", m_busy_o); end
        #1 rst_i = 1'b1;
        #1;
        total++; if (dmem.req !== 1'b0 || m_busy_o !== 1'b0) begin bad++; $display("FAIL midwait_drop got req=%0b busy=%0b want 0/0", dmem.req, m_busy_o); end
        total++; if (W_icode_o !== I_NOP || W_stat_o !== S_AOK || W_dstM_o !== R_NONE) begin
            bad++; $display("FAIL midwait_W got icode=%0h stat=%0d dstM=%0h want 1/1/f", W_icode_o, W_stat_o, W_dstM_o); end
        drive_m(I_NOP, 64'h0, 64'h0, R_NONE, R_NONE);
        next_edge();
        rst_i = 1'b0;
        drive_mem(1'b1, 1'b0, 64'hBEEF);
        @(negedge clk_i);
        total++; if (dmem.req !== 1'b0 || m_valM_o !== 64'h0 || m_stat_o !== S_AOK) begin
            bad++; $display("FAIL late_ack got req=%0b valM=%0h stat=%0d want 0/0/1", dmem.req, m_valM_o, m_stat_o); end
        next_edge();
        drive_m(I_MRMOVQ, 64'h300, 64'h0, R_NONE, 4'h6);
        drive_mem(1'b1, 1'b0, 64'h1234);
        @(negedge clk_i);
        total++; if (dmem.req !== 1'b1 || m_busy_o !== 1'b0) begin bad++; $display("FAIL restart_comb got req=%0b busy=%0b want 1/0", dmem.req, m_busy_o); end
        next_edge();
        total++; if (W_valM_o !== 64'h1234 || W_icode_o !== I_MRMOVQ) begin bad++; $display("FAIL restart_W got valM=%0h icode=%0h want 1234/5", W_valM_o, W_icode_o); end
        drive_m(I_NOP, 64'h0, 64'h0, R_NONE, R_NONE);
        drive_mem(1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_boundary_addr();
        test_store_wait();
        test_back_to_back();
        test_range_fault();
        test_timeout();
        test_bus_error();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
